// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity encodings, TX FSM states and
// a parameter sanity check used at elaboration.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic bit params_ok(int unsigned clks_per_bit, int unsigned data_bits,
                                     int unsigned parity, int unsigned stop_bits,
                                     int unsigned fifo_depth);
        return (clks_per_bit >= 2) && (data_bits >= 5) && (data_bits <= 9) &&
               (parity <= PAR_ODD) && ((stop_bits == 1) || (stop_bits == 2)) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count; shared by the TX
// and RX paths. Push when full and pop when empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (PtrW + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + (PtrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - (PtrW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: buffers words in a FIFO and serialises them as
// start, LSB-first data, optional parity and 1-2 stop bits, back-to-back without gaps.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    if (!params_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
        $fatal(1, "uart_tx_param: illegal parameter combination");
    end

    tx_state_e             state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  push, pop, full, empty, bit_end;
    logic [DATA_BITS-1:0]  head;

    assign din_ready = ~full;
    assign push      = din_valid & ~full;
    assign tx_data   = tx_q;
    assign busy      = (state_q != StIdle) | ~empty;
    assign bit_end   = (baud_q == BaudW'(CLKS_PER_BIT - 1));

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (din),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + BaudW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next start bit so frames are gap-free
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = 1'b0;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is computed from the next state so the pin is registered yet not delayed
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d ^ (PARITY == PAR_ODD);
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations driven by directed and random words,
// with the serial line compared clock-by-clock against a frame model.
module tb_uart_tx_param;

    localparam int N = 4;

    logic       clk;
    logic       rstn;
    logic [7:0] din0, din3;
    logic [6:0] din1, din2;
    logic       valid [N];
    logic       rdy   [N];
    logic       tx    [N];
    logic       busy  [N];
    logic [2:0] lvl   [N];

    int cpb_c [N] = '{4, 4, 4, 217};
    int db_c  [N] = '{8, 7, 7, 8};
    int par_c [N] = '{0, 1, 2, 0};
    int sb_c  [N] = '{1, 2, 1, 1};

    int errors = 0;
    int checks = 0;

    int         sel = 0;
    bit         rec = 0;
    logic       txlog [$];
    logic       busylog [$];
    logic [7:0] words [$];

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.clk(clk), .rstn(rstn), .din(din0), .din_valid(valid[0]), .din_ready(rdy[0]),
          .tx_data(tx[0]), .busy(busy[0]), .fifo_level(lvl[0]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut1 (.clk(clk), .rstn(rstn), .din(din1), .din_valid(valid[1]), .din_ready(rdy[1]),
          .tx_data(tx[1]), .busy(busy[1]), .fifo_level(lvl[1]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut2 (.clk(clk), .rstn(rstn), .din(din2), .din_valid(valid[2]), .din_ready(rdy[2]),
          .tx_data(tx[2]), .busy(busy[2]), .fifo_level(lvl[2]));
    uart_tx_param #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut3 (.clk(clk), .rstn(rstn), .din(din3), .din_valid(valid[3]), .din_ready(rdy[3]),
          .tx_data(tx[3]), .busy(busy[3]), .fifo_level(lvl[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line recorder: one sample per clock, taken well after the edge
    always begin
        @(posedge clk);
        #2;
        if (rec) begin
            txlog.push_back(tx[sel]);
            busylog.push_back(busy[sel]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(int s, logic [7:0] w);
        case (s)
            0: din0 = w;
            1: din1 = w[6:0];
            2: din2 = w[6:0];
            default: din3 = w;
        endcase
    endtask

    // Present a word, wait (bounded) for ready, complete the handshake on the next edge
    task automatic push(int s, logic [7:0] w);
        int guard = 0;
        set_din(s, w);
        valid[s] = 1'b1;
        while (!rdy[s] && guard < 2000) begin
            tick();
            guard++;
        end
        check("push_ready", rdy[s], 1);
        tick();
        valid[s] = 1'b0;
        set_din(s, ~w);
        words.push_back(w);
    endtask

    task automatic start_rec(int s);
        sel = s;
        txlog.delete();
        busylog.delete();
        rec = 1'b1;
    endtask

    // Model: expected line, one entry per clock, from the accept edge onward
    task automatic expect_log(int s, string tag);
        logic exp_tx [$];
        logic bits [$];
        int   guard = 0;
        int   ones;
        exp_tx.push_back(1'b1);
        foreach (words[k]) begin
            bits.delete();
            ones = 0;
            bits.push_back(1'b0);
            for (int i = 0; i < db_c[s]; i++) begin
                bits.push_back(words[k][i]);
                ones += int'(words[k][i]);
            end
            if (par_c[s] == 1) bits.push_back((ones % 2) == 1);
            if (par_c[s] == 2) bits.push_back((ones % 2) == 0);
            for (int i = 0; i < sb_c[s]; i++) bits.push_back(1'b1);
            foreach (bits[b]) for (int c = 0; c < cpb_c[s]; c++) exp_tx.push_back(bits[b]);
        end
        exp_tx.push_back(1'b1);
        while (txlog.size() < exp_tx.size() && guard < exp_tx.size() + 100) begin
            tick();
            guard++;
        end
        rec = 1'b0;
        check({tag, "_len"}, txlog.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < txlog.size(); i++) begin
            check($sformatf("%s_tx@%0d", tag, i), txlog[i], exp_tx[i]);
            check($sformatf("%s_busy@%0d", tag, i), busylog[i], (i != exp_tx.size() - 1));
            if (txlog[i] !== exp_tx[i]) break;
        end
        check({tag, "_level_end"}, lvl[s], 0);
    endtask

    initial begin
        logic [7:0] w;
        int         zeros;
        int         guard;

        rstn = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        for (int i = 0; i < N; i++) valid[i] = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_tx%0d", i), tx[i], 1);
            check($sformatf("reset_ready%0d", i), rdy[i], 1);
            check($sformatf("reset_busy%0d", i), busy[i], 0);
            check($sformatf("reset_level%0d", i), lvl[i], 0);
        end
        rstn = 1'b1;
        tick();

        // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1 at 4 clocks each
        words.delete();
        push(0, 8'hA5);
        start_rec(0);
        check("a5_busy_after_accept", busy[0], 1);
        check("a5_level_after_accept", lvl[0], 1);
        expect_log(0, "a5");

        // Idle-accept latency with an all-zero word
        words.delete();
        push(0, 8'h00);
        start_rec(0);
        expect_log(0, "zero");

        // 7E2: 0x41 then 0x43 back-to-back
        words.delete();
        push(1, 8'h41);
        start_rec(1);
        push(1, 8'h43);
        expect_log(1, "7e2");

        // 7O1: 0x41
        words.delete();
        push(2, 8'h41);
        start_rec(2);
        expect_log(2, "7o1");

        // Fill the FIFO during the first frame, then push into full across a pop
        words.delete();
        push(0, 8'($urandom_range(0, 255)));
        start_rec(0);
        for (int i = 0; i < 4; i++) push(0, 8'($urandom_range(0, 255)));
        check("fill_ready_low", rdy[0], 0);
        check("fill_level4", lvl[0], 4);
        w = 8'($urandom_range(0, 255));
        set_din(0, w);
        valid[0] = 1'b1;
        guard = 0;
        while (!rdy[0] && guard < 200) begin
            tick();
            guard++;
        end
        check("full_pop_refused_level", lvl[0], 3);
        check("full_pop_ready", rdy[0], 1);
        tick();
        valid[0] = 1'b0;
        words.push_back(w);
        check("full_refill_level", lvl[0], 4);
        expect_log(0, "fill");

        // 8N1 at 217 clocks/bit: reset during data bit 3, with a second word queued
        push(3, 8'h52);
        push(3, 8'h33);
        for (int i = 0; i < 968; i++) tick();
        check("mid_bit3_tx", tx[3], 0);
        check("mid_level", lvl[3], 1);
        rstn = 1'b0;
        tick();
        check("rst_tx", tx[3], 1);
        check("rst_level", lvl[3], 0);
        check("rst_busy", busy[3], 0);
        check("rst_ready", rdy[3], 1);
        rstn = 1'b1;
        zeros = 0;
        for (int i = 0; i < 3 * 217; i++) begin
            tick();
            if (tx[3] !== 1'b1) zeros++;
        end
        check("rst_no_resume", zeros, 0);
        check("rst_busy_after", busy[3], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with input FIFO, replacing the fixed 8N1 transmitter. It accepts words over a valid/ready handshake, buffers up to FIFO_DEPTH words, and serialises each as start, LSB-first data, optional parity and 1 or 2 stop bits at a baud period of CLKS_PER_BIT clocks. Back-to-back frames are sent with no idle gap. It sits between the counter/buffer logic and the board TX pin.

## Interface
- CLKS_PER_BIT, 217: clocks per bit period; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: buffered words; power of two, ≥ 2.

- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- din  in  DATA_BITS  word to send.
- din_valid  in  1  din is presented.
- din_ready  out  1  FIFO not full; word accepted on an edge with din_valid & din_ready.
- tx_data  out  1  serial line, idle high, registered.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_data = 1. If the FIFO is non-empty, pop the head into a shift register, clear the bit counter and baud counter, and go to START.
- START: tx_data = 0 for one bit period, then go to DATA.
- DATA: shift out LSB first for DATA_BITS periods. Parity accumulates over the shifted bits. Then go to PARITY if PARITY ≠ 0, else STOP.
- PARITY: even means the XOR of the data bits; odd means its inverse. One bit period.
- STOP: tx_data = 1 for STOP_BITS periods. At the end, pop the next word if the FIFO is non-empty and go directly to START; otherwise go to IDLE.
- The shift register captures the word at pop. Changes to din after acceptance never affect a frame.
- Baud counter counts 0..CLKS_PER_BIT-1. The bit boundary is at terminal count.
- FIFO accepts a word on din_valid & din_ready. din_ready = !full, with no same-cycle bypass: when full, a push is refused even if a pop happens that cycle.
- A push into an empty FIFO while idle is popped on the following edge.
- Reset (rstn low at an edge), including mid-frame: FSM goes to IDLE, tx_data = 1, FIFO is emptied, counters are cleared. No partial frame resumes.

## Timing
- Reset values: tx_data = 1, din_ready = 1, busy = 0, fifo_level = 0.
- Latency: word accepted at edge T into an empty, idle block → pop at T+1 → tx_data falls at edge T+1.
- Every bit is exactly CLKS_PER_BIT clocks.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) clocks.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- busy rises at edge T (accept) and falls on the edge that enters IDLE with the FIFO empty.
- fifo_level updates on the same edge as a push or pop. A simultaneous push and pop leaves it unchanged.

## Structure
- Shared package uart_pkg holds: the PARITY encodings (PAR_NONE, PAR_EVEN, PAR_ODD), the FSM state encoding, and a parameter-legality check function.
- One sub-module, uart_tx_fifo: synchronous FIFO with parameters width and depth, ports push, pop, full, empty and level, and wrap-around pointers. This is reused by the planned RX path.
- The top level contains the FSM, baud counter, bit counter, shift register and parity register.

## Test plan
- Reset mid-frame at 8N1, 217 clocks/bit: drop rstn during bit 3 → tx_data = 1 next edge, fifo_level = 0, and no further start bit.
- 8N1, CLKS_PER_BIT = 4, send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each 4 clocks; total 40 clocks.
- 7E2, send 0x41 → parity bit 0 and two stop bits; 0x43 → parity bit 1. 7O1, send 0x41 → parity bit 1.
- Fill the FIFO (depth 4) while the first frame is active → din_ready low after the 4th buffered word; the 5th word is held until the first pop; all words are sent gap-free, in order.
- Push into a full FIFO on the same edge as a pop → push refused; fifo_level goes down by 1; no word lost or duplicated.
- Idle-accept latency: accept 0x00 at edge T → tx_data low at edge T+1. busy stays high until 10 × CLKS_PER_BIT clocks after the start bit began.
